gshare_cbp: RTL and testbench

Parametrised gshare conditional branch predictor for the five-stage pipeline; the successor to the single-table CBP. Fetch looks up a saturating-counter pattern table indexed by PC XOR a speculative global history register (GHR). The history snapshot travels down the pipeline with the branch. Execute repairs the GHR on a redirect, and writeback trains the table with the resolved direction. Built-in performance counters track committed branches and mispredicts.

---
 rtl/gshare_cbp_if.sv | 36 +++
 rtl/gshare_cbp.sv | 95 +++++++++
 tb/tb_gshare_cbp.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/gshare_cbp_if.sv
// rtl/gshare_cbp_if.sv - fetch/execute/writeback signal bundle for the gshare predictor
interface gshare_cbp_if #(
  parameter int PC_WIDTH  = 32,
  parameter int HIST_BITS = 6
);
  logic [PC_WIDTH-1:0]  F_PC_i;
  logic                 F_lookup_vaild_i;
  logic                 F_stall_i;
  logic                 F_train_predict_o;
  logic [HIST_BITS-1:0] F_ghr_o;
  logic                 E_repair_i;
  logic [HIST_BITS-1:0] E_repair_ghr_i;
  logic                 E_repair_is_branch_i;
  logic                 E_repair_taken_i;
  logic                 MD_train_vaild_i;
  logic                 MD_train_taken_i;
  logic                 MD_train_predict_i;
  logic [PC_WIDTH-1:0]  MD_PC_i;
  logic [HIST_BITS-1:0] MD_ghr_i;
  logic [31:0]          cnt_branch_o;
  logic [31:0]          cnt_miss_o;

  modport master (
    output F_PC_i, F_lookup_vaild_i, F_stall_i,
    output E_repair_i, E_repair_ghr_i, E_repair_is_branch_i, E_repair_taken_i,
    output MD_train_vaild_i, MD_train_taken_i, MD_train_predict_i, MD_PC_i, MD_ghr_i,
    input  F_train_predict_o, F_ghr_o, cnt_branch_o, cnt_miss_o
  );

  modport slave (
    input  F_PC_i, F_lookup_vaild_i, F_stall_i,
    input  E_repair_i, E_repair_ghr_i, E_repair_is_branch_i, E_repair_taken_i,
    input  MD_train_vaild_i, MD_train_taken_i, MD_train_predict_i, MD_PC_i, MD_ghr_i,
    output F_train_predict_o, F_ghr_o, cnt_branch_o, cnt_miss_o
  );
endinterface

// File: rtl/gshare_cbp.sv
// rtl/gshare_cbp.sv - gshare predictor: PC^GHR indexed counter table, speculative GHR with repair
module gshare_cbp #(
  parameter int PC_WIDTH   = 32,
  parameter int INDEX_BITS = 6,
  parameter int HIST_BITS  = 6,
  parameter int CTR_BITS   = 2,
  parameter int RESET_CTR  = 1
) (
  input  logic           clk_i,
  input  logic           rst,
  gshare_cbp_if.slave    bus
);
  localparam int DEPTH = 1 << INDEX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'(RESET_CTR);

  logic [CTR_BITS-1:0]   tbl_q [DEPTH];
  logic [CTR_BITS-1:0]   tbl_d [DEPTH];
  logic [HIST_BITS-1:0]  spec_ghr_q, spec_ghr_d;
  logic [31:0]           cnt_branch_q, cnt_branch_d;
  logic [31:0]           cnt_miss_q, cnt_miss_d;
  logic [HIST_BITS-1:0]  rep_h, eff_h;
  logic [INDEX_BITS-1:0] f_idx, md_idx;
  logic [CTR_BITS-1:0]   md_ctr;
  logic                  f_pred;
  logic                  lookup_fire;
  logic                  unused_pc_bits;

  // Shifting left drops the oldest bit; also covers the single-bit history case.
  function automatic logic [HIST_BITS-1:0] shift_in(input logic [HIST_BITS-1:0] h, input logic b);
    return (h << 1) | HIST_BITS'(b);
  endfunction

  always_comb begin
    rep_h = bus.E_repair_ghr_i;
    if (bus.E_repair_is_branch_i) begin
      rep_h = shift_in(bus.E_repair_ghr_i, bus.E_repair_taken_i);
    end
    eff_h = bus.E_repair_i ? rep_h : spec_ghr_q;
  end

  assign f_idx       = bus.F_PC_i[INDEX_BITS+1:2] ^ INDEX_BITS'(eff_h);
  assign md_idx      = bus.MD_PC_i[INDEX_BITS+1:2] ^ INDEX_BITS'(bus.MD_ghr_i);
  assign f_pred      = tbl_q[f_idx][CTR_BITS-1];
  assign md_ctr      = tbl_q[md_idx];
  assign lookup_fire = bus.F_lookup_vaild_i & ~bus.F_stall_i;

  assign bus.F_train_predict_o = f_pred;
  assign bus.F_ghr_o           = eff_h;
  assign bus.cnt_branch_o      = cnt_branch_q;
  assign bus.cnt_miss_o        = cnt_miss_q;

  assign unused_pc_bits = ^{bus.F_PC_i[PC_WIDTH-1:INDEX_BITS+2], bus.F_PC_i[1:0],
                            bus.MD_PC_i[PC_WIDTH-1:INDEX_BITS+2], bus.MD_PC_i[1:0]};

  // Lookups read tbl_q, so a same-cycle training write is only seen next cycle.
  always_comb begin
    spec_ghr_d   = spec_ghr_q;
    tbl_d        = tbl_q;
    cnt_branch_d = cnt_branch_q;
    cnt_miss_d   = cnt_miss_q;
    if (lookup_fire) begin
      spec_ghr_d = shift_in(eff_h, f_pred);
    end else if (bus.E_repair_i) begin
      spec_ghr_d = rep_h;
    end
    if (bus.MD_train_vaild_i) begin
      if (bus.MD_train_taken_i) begin
        tbl_d[md_idx] = (md_ctr == CTR_MAX) ? md_ctr : md_ctr + CTR_BITS'(1);
      end else begin
        tbl_d[md_idx] = (md_ctr == '0) ? md_ctr : md_ctr - CTR_BITS'(1);
      end
      cnt_branch_d = cnt_branch_q + 32'd1;
      if (bus.MD_train_predict_i != bus.MD_train_taken_i) begin
        cnt_miss_d = cnt_miss_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= CTR_RST;
      end
      spec_ghr_q   <= '0;
      cnt_branch_q <= '0;
      cnt_miss_q   <= '0;
    end else begin
      tbl_q        <= tbl_d;
      spec_ghr_q   <= spec_ghr_d;
      cnt_branch_q <= cnt_branch_d;
      cnt_miss_q   <= cnt_miss_d;
    end
  end
endmodule

// File: tb/tb_gshare_cbp.sv
// tb/tb_gshare_cbp.sv - directed scoreboard bench for gshare_cbp (6-bit index, 4-bit history)
module tb_gshare_cbp;
  localparam int PCW = 32;
  localparam int IB  = 6;
  localparam int HB  = 4;
  localparam int CB  = 2;
  localparam int RC  = 1;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } sb_t;
  sb_t sb[$];

  gshare_cbp_if #(.PC_WIDTH(PCW), .HIST_BITS(HB)) bus ();

  gshare_cbp #(
    .PC_WIDTH(PCW), .INDEX_BITS(IB), .HIST_BITS(HB), .CTR_BITS(CB), .RESET_CTR(RC)
  ) dut (
    .clk_i (clk),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  task automatic expect_val(input string tag, input logic [31:0] v);
    sb.push_back('{tag, v});
  endtask

  task automatic check(input logic [31:0] obs);
    sb_t e;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: observed %0h required an expectation", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic idle();
    bus.F_PC_i = '0;               bus.F_lookup_vaild_i = 1'b0;  bus.F_stall_i = 1'b0;
    bus.E_repair_i = 1'b0;         bus.E_repair_ghr_i = '0;
    bus.E_repair_is_branch_i = 1'b0; bus.E_repair_taken_i = 1'b0;
    bus.MD_train_vaild_i = 1'b0;   bus.MD_train_taken_i = 1'b0;  bus.MD_train_predict_i = 1'b0;
    bus.MD_PC_i = '0;              bus.MD_ghr_i = '0;
  endtask

  task automatic look(input logic [31:0] pc, input logic stall);
    bus.F_lookup_vaild_i = 1'b1;
    bus.F_PC_i           = pc;
    bus.F_stall_i        = stall;
  endtask

  task automatic train(input logic [31:0] pc, input logic [HB-1:0] ghr, input logic taken, input logic pred);
    bus.MD_train_vaild_i   = 1'b1;
    bus.MD_PC_i            = pc;
    bus.MD_ghr_i           = ghr;
    bus.MD_train_taken_i   = taken;
    bus.MD_train_predict_i = pred;
  endtask

  task automatic repair(input logic [HB-1:0] ghr, input logic is_br, input logic taken);
    bus.E_repair_i           = 1'b1;
    bus.E_repair_ghr_i       = ghr;
    bus.E_repair_is_branch_i = is_br;
    bus.E_repair_taken_i     = taken;
  endtask

  task automatic train_step(input logic [31:0] pc, input logic [HB-1:0] ghr, input logic taken,
                            input logic exp_pred, input string tag);
    train(pc, ghr, taken, taken);
    @(negedge clk);
    bus.MD_train_vaild_i = 1'b0;
    #1;
    expect_val(tag, 32'(exp_pred));
    check(32'(bus.F_train_predict_o));
  endtask

  task automatic pulse_rst();
    #1 rst = 1'b1;
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Build up some state, then clear it asynchronously between edges.
    train(32'h100, 4'b0000, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    bus.MD_train_vaild_i = 1'b0;
    look(32'h100, 1'b0);
    @(negedge clk);
    look(32'h100, 1'b1);
    #1;
    expect_val("pre_branch", 32'd2);  check(bus.cnt_branch_o);
    expect_val("pre_ghr", 32'h1);     check(32'(bus.F_ghr_o));
    #1 rst = 1'b1;
    #1;
    expect_val("rst_async_branch", 32'd0); check(bus.cnt_branch_o);
    expect_val("rst_async_miss", 32'd0);   check(bus.cnt_miss_o);
    expect_val("rst_async_ghr", 32'd0);    check(32'(bus.F_ghr_o));
    expect_val("rst_async_pred", 32'd0);   check(32'(bus.F_train_predict_o));
    #1 rst = 1'b0;
    @(negedge clk);
    #1;
    expect_val("reset_pred", 32'd0);   check(32'(bus.F_train_predict_o));
    expect_val("reset_ghr", 32'd0);    check(32'(bus.F_ghr_o));
    expect_val("reset_branch", 32'd0); check(bus.cnt_branch_o);
    expect_val("reset_miss", 32'd0);   check(bus.cnt_miss_o);

    // Saturation on index 0, observed through a stalled lookup of 0x100.
    train_step(32'h100, 4'b0000, 1'b1, 1'b1, "sat_t1");
    train_step(32'h100, 4'b0000, 1'b1, 1'b1, "sat_t2");
    train_step(32'h100, 4'b0000, 1'b1, 1'b1, "sat_t3");
    train_step(32'h100, 4'b0000, 1'b0, 1'b1, "sat_n1");
    train_step(32'h100, 4'b0000, 1'b0, 1'b0, "sat_n2");
    train_step(32'h100, 4'b0000, 1'b0, 1'b0, "sat_n3");
    train_step(32'h100, 4'b0000, 1'b0, 1'b0, "sat_n4");
    train_step(32'h100, 4'b0000, 1'b1, 1'b0, "sat_t4");
    train_step(32'h100, 4'b0000, 1'b1, 1'b1, "sat_t5");

    // XOR indexing: PC 0x104 with history 0001 aliases onto index 0.
    pulse_rst();
    train_step(32'h104, 4'b0001, 1'b1, 1'b1, "xor_t1");
    train_step(32'h104, 4'b0001, 1'b1, 1'b1, "xor_t2");
    look(32'h104, 1'b1);
    #1;
    expect_val("xor_idx1_pred", 32'd0); check(32'(bus.F_train_predict_o));
    expect_val("xor_idx1_ghr", 32'd0);  check(32'(bus.F_ghr_o));

    // Stalled lookup must not advance history.
    look(32'h100, 1'b1);
    @(negedge clk);
    #1;
    expect_val("stall_ghr", 32'd0);  check(32'(bus.F_ghr_o));
    expect_val("stall_pred", 32'd1); check(32'(bus.F_train_predict_o));

    repair(4'b0101, 1'b1, 1'b1);
    #1;
    expect_val("rep_same_ghr", 32'hB); check(32'(bus.F_ghr_o));
    expect_val("rep_same_pred", 32'd0); check(32'(bus.F_train_predict_o));
    @(negedge clk);
    bus.E_repair_i = 1'b0;
    #1;
    expect_val("rep_after_ghr", 32'hB); check(32'(bus.F_ghr_o));

    repair(4'b0011, 1'b0, 1'b1);
    #1;
    expect_val("nbr_same_ghr", 32'h3); check(32'(bus.F_ghr_o));
    @(negedge clk);
    bus.E_repair_i = 1'b0;
    #1;
    expect_val("nbr_after_ghr", 32'h3); check(32'(bus.F_ghr_o));

    // Repair and consumed lookup together: 0x2C ^ 1011 lands on index 0 (predicts taken).
    repair(4'b0101, 1'b1, 1'b1);
    look(32'h2C, 1'b0);
    #1;
    expect_val("fire_ghr", 32'hB);  check(32'(bus.F_ghr_o));
    expect_val("fire_pred", 32'd1); check(32'(bus.F_train_predict_o));
    @(negedge clk);
    bus.E_repair_i = 1'b0;
    look(32'h100, 1'b1);
    #1;
    expect_val("fire_after_ghr", 32'h7); check(32'(bus.F_ghr_o));

    // Read-before-write: history 0111 with PC 0x108 -> index 5, counter 1.
    look(32'h108, 1'b1);
    train(32'h108, 4'b0111, 1'b1, 1'b1);
    #1;
    expect_val("rbw_same", 32'd0); check(32'(bus.F_train_predict_o));
    @(negedge clk);
    bus.MD_train_vaild_i = 1'b0;
    #1;
    expect_val("rbw_next", 32'd1); check(32'(bus.F_train_predict_o));

    // Performance counters: 10 commits, the first 3 mispredicted.
    pulse_rst();
    for (int i = 0; i < 10; i++) begin
      logic tk;
      tk = 1'(i & 1);
      train(32'h200, 4'b0000, tk, (i < 3) ? ~tk : tk);
      if (i == 0) begin
        #1;
        expect_val("cnt_pre_edge", 32'd0); check(bus.cnt_branch_o);
      end
      @(negedge clk);
    end
    bus.MD_train_vaild_i = 1'b0;
    #1;
    expect_val("cnt_branch_10", 32'd10); check(bus.cnt_branch_o);
    expect_val("cnt_miss_3", 32'd3);     check(bus.cnt_miss_o);

    force dut.cnt_branch_q = 32'hFFFF_FFFF;
    force dut.cnt_miss_q   = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_branch_q;
    release dut.cnt_miss_q;
    train(32'h200, 4'b0000, 1'b1, 1'b0);
    @(negedge clk);
    bus.MD_train_vaild_i = 1'b0;
    #1;
    expect_val("wrap_branch", 32'd0); check(bus.cnt_branch_o);
    expect_val("wrap_miss", 32'd0);   check(bus.cnt_miss_o);

    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: observed %0d entries required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
